// File: rtl/adma_dm_axi_aw_if.sv
// AXI AW channel plus W-stage ATX info push, bundled for the DMA data-mover write path.
interface adma_dm_axi_aw_if #(
    parameter int unsigned ATX_ADDR_W = 32,
    parameter int unsigned ATX_LEN_W  = 8
);

    logic [ATX_ADDR_W-1:0] m_awaddr_o;
    logic [ATX_LEN_W-1:0]  m_awlen_o;
    logic [1:0]            m_awburst_o;
    logic [2:0]            m_awsize_o;
    logic                  m_awvalid_o;
    logic                  m_awready_i;
    logic [ATX_LEN_W-1:0]  atx_awlen;
    logic                  atx_vld;
    logic                  atx_rdy;

    // Burst issuer side
    modport master (
        output m_awaddr_o,
        output m_awlen_o,
        output m_awburst_o,
        output m_awsize_o,
        output m_awvalid_o,
        input  m_awready_i,
        output atx_awlen,
        output atx_vld,
        input  atx_rdy
    );

    // AXI slave / W-stage FIFO side
    modport slave (
        input  m_awaddr_o,
        input  m_awlen_o,
        input  m_awburst_o,
        input  m_awsize_o,
        input  m_awvalid_o,
        output m_awready_i,
        input  atx_awlen,
        input  atx_vld,
        output atx_rdy
    );

endinterface

// File: rtl/adma_dm_axi_aw.sv
// AW-side burst issuer: splits one destination transfer into AXI INCR bursts bounded by
// the maximum burst length and the address boundary, issues each on AW and pushes its
// AWLEN to the W-stage ATX FIFO, then pulses xfer_done.
module adma_dm_axi_aw #(
    parameter int unsigned ATX_ADDR_W     = 32,
    parameter int unsigned ATX_LEN_W      = 8,
    parameter int unsigned ATX_DST_DATA_W = 256,
    parameter int unsigned ATX_XFER_W     = 16,
    parameter int unsigned ATX_BOUND      = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ATX_ADDR_W-1:0] xfer_addr,
    input  logic [ATX_XFER_W-1:0] xfer_beats,
    input  logic                  xfer_vld,
    output logic                  xfer_rdy,
    output logic                  xfer_done,
    output logic                  busy,
    adma_dm_axi_aw_if.master      bus
);

    localparam int unsigned BYTES     = ATX_DST_DATA_W / 8;
    localparam int unsigned SIZE_W    = $clog2(BYTES);
    localparam int unsigned MAX_BURST = 2 ** ATX_LEN_W;
    localparam int unsigned W_AX      = (ATX_ADDR_W > ATX_XFER_W) ? ATX_ADDR_W : ATX_XFER_W;
    localparam int unsigned CALC_W    = ((W_AX > ATX_LEN_W + 1) ? W_AX : ATX_LEN_W + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ATX_ADDR_W-1:0] addr_q, addr_d;
    logic [ATX_XFER_W-1:0] rem_q, rem_d;
    logic [CALC_W-1:0]     burst_q, burst_d;
    logic [ATX_ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ATX_LEN_W-1:0]  awlen_q, awlen_d;
    logic                  awvalid_q, awvalid_d;
    logic                  atxvld_q, atxvld_d;
    logic                  done_q, done_d;

    logic [CALC_W-1:0]     room_c;
    logic [CALC_W-1:0]     burst_c;
    logic                  aw_ok_c;
    logic                  atx_ok_c;

    // Beats left before the boundary, capped by max burst length and remaining beats
    always_comb begin
        room_c  = (CALC_W'(ATX_BOUND) - (CALC_W'(addr_q) % CALC_W'(ATX_BOUND))) >> SIZE_W;
        burst_c = CALC_W'(rem_q);
        if (CALC_W'(MAX_BURST) < burst_c) begin
            burst_c = CALC_W'(MAX_BURST);
        end
        if (room_c < burst_c) begin
            burst_c = room_c;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        burst_d   = burst_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awvalid_d = awvalid_q;
        atxvld_d  = atxvld_q;
        done_d    = 1'b0;
        aw_ok_c   = !awvalid_q || bus.m_awready_i;
        atx_ok_c  = !atxvld_q || bus.atx_rdy;

        case (state_q)
            IDLE: begin
                if (xfer_vld) begin
                    addr_d = xfer_addr & ~ATX_ADDR_W'(BYTES - 1);
                    rem_d  = xfer_beats;
                    if (xfer_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                burst_d   = burst_c;
                awaddr_d  = addr_q;
                awlen_d   = ATX_LEN_W'(burst_c - CALC_W'(1));
                awvalid_d = 1'b1;
                atxvld_d  = 1'b1;
                state_d   = ISSUE;
            end

            ISSUE: begin
                // AW and ATX retire independently; the burst completes once both have
                if (awvalid_q && bus.m_awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (atxvld_q && bus.atx_rdy) begin
                    atxvld_d = 1'b0;
                end
                if (aw_ok_c && atx_ok_c) begin
                    addr_d = addr_q + ATX_ADDR_W'(burst_q << SIZE_W);
                    rem_d  = rem_q - ATX_XFER_W'(burst_q);
                    if (rem_q == ATX_XFER_W'(burst_q)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            burst_q   <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            atxvld_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            burst_q   <= burst_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awvalid_q <= awvalid_d;
            atxvld_q  <= atxvld_d;
            done_q    <= done_d;
        end
    end

    // Status decodes straight off the state register
    assign xfer_rdy  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign xfer_done = done_q;

    // AW channel and ATX push, all from registers
    assign bus.m_awaddr_o  = awaddr_q;
    assign bus.m_awlen_o   = awlen_q;
    assign bus.m_awburst_o = 2'b01;
    assign bus.m_awsize_o  = 3'(SIZE_W);
    assign bus.m_awvalid_o = awvalid_q;
    assign bus.atx_awlen   = awlen_q;
    assign bus.atx_vld     = atxvld_q;

endmodule

// File: tb/tb_adma_dm_axi_aw.sv
// Bench for adma_dm_axi_aw: randomized transfers and ready patterns against a
// burst-splitting reference model (256-bit data, 8-bit AWLEN, 4KB boundary).
module tb_adma_dm_axi_aw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] xfer_addr;
    logic [15:0] xfer_beats;
    logic        xfer_vld;
    logic        xfer_rdy;
    logic        xfer_done;
    logic        busy;

    adma_dm_axi_aw_if #(.ATX_ADDR_W(32), .ATX_LEN_W(8)) bus ();

    adma_dm_axi_aw #(
        .ATX_ADDR_W(32), .ATX_LEN_W(8), .ATX_DST_DATA_W(256), .ATX_XFER_W(16), .ATX_BOUND(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .xfer_addr(xfer_addr), .xfer_beats(xfer_beats),
        .xfer_vld(xfer_vld), .xfer_rdy(xfer_rdy), .xfer_done(xfer_done), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_addr[$];
    int          exp_len[$];
    logic [31:0] obs_addr[$];
    int          obs_len[$];
    int          obs_atx[$];
    int          n_done, done_lat, lat_bad, hold_bad, stall_bad, busy_bad, attr_bad;
    bit          timeout;

    // Reference: split a transfer into bursts from the address/length rules alone
    task automatic build_model(input logic [31:0] a0, input int beats);
        longint a;
        int     r, room, b;
        exp_addr.delete();
        exp_len.delete();
        a = longint'(a0 & ~32'd31);
        r = beats;
        while (r > 0) begin
            room = int'((64'd4096 - (a % 4096)) / 32);
            b = r;
            if (b > 256)  b = 256;
            if (b > room) b = room;
            exp_addr.push_back(a[31:0]);
            exp_len.push_back(b - 1);
            a = a + longint'(b) * 32;
            r = r - b;
        end
    endtask

    // Drive one transfer, apply a ready pattern and record what the DUT issues.
    // mode 0: random readies, 1: readies high, 2: AWREADY held low 5 cycles, 3: atx_rdy held low 5 cycles
    task automatic drive_xfer(input logic [31:0] a, input int beats, input int mode);
        int          cyc, req_cyc, last_evt, start_cyc, done_cyc, since, nexp;
        bit          active, aw_done, atx_done, req_fire, cur_aw, cur_atx, done_seen;
        logic [31:0] b_addr;
        logic [7:0]  b_len;
        build_model(a, beats);
        nexp = exp_addr.size();
        obs_addr.delete(); obs_len.delete(); obs_atx.delete();
        n_done = 0; done_lat = -1; lat_bad = 0; hold_bad = 0; stall_bad = 0; busy_bad = 0; attr_bad = 0;
        timeout = 0; active = 0; aw_done = 0; atx_done = 0; done_seen = 0;
        cyc = 0; req_cyc = -1; last_evt = -100; start_cyc = 0; done_cyc = 0; b_addr = '0; b_len = '0;
        @(negedge clk);
        xfer_addr  = a;
        xfer_beats = 16'(beats);
        xfer_vld   = 1'b1;
        while (1) begin
            cur_aw  = bus.m_awvalid_o;
            cur_atx = bus.atx_vld;
            if (!active && (cur_aw || cur_atx)) begin
                if (done_seen || req_cyc < 0) hold_bad++;
                if (cyc != last_evt + 2) lat_bad++;
                if (!(cur_aw && cur_atx)) lat_bad++;
                if (bus.m_awburst_o !== 2'b01 || bus.m_awsize_o !== 3'd5) attr_bad++;
                active = 1; start_cyc = cyc; aw_done = 0; atx_done = 0;
                b_addr = bus.m_awaddr_o; b_len = bus.m_awlen_o;
            end else if (active) begin
                if (cur_aw == aw_done) hold_bad++;
                if (cur_atx == atx_done) hold_bad++;
            end
            if (active && cur_aw && (bus.m_awaddr_o !== b_addr || bus.m_awlen_o !== b_len)) hold_bad++;
            if (active && cur_atx && bus.atx_awlen !== b_len) hold_bad++;
            since = cyc - start_cyc;
            if (active && mode == 2 && ((since == 1 && cur_atx) || (since <= 4 && !cur_aw))) stall_bad++;
            if (active && mode == 3 && ((since == 1 && cur_aw) || (since <= 4 && !cur_atx))) stall_bad++;
            if (xfer_done) begin
                n_done++;
                if (!done_seen) begin
                    done_seen = 1; done_cyc = cyc; done_lat = cyc - last_evt;
                end
                if (active || !xfer_rdy || busy) busy_bad++;
            end else if (req_cyc >= 0 && cyc > req_cyc && !done_seen && nexp > 0 && (xfer_rdy || !busy)) begin
                busy_bad++;
            end
            if (done_seen && cyc >= done_cyc + 1) break;
            if (cyc >= 5000) begin
                timeout = 1;
                break;
            end
            case (mode)
                1: begin bus.m_awready_i = 1'b1; bus.atx_rdy = 1'b1; end
                2: begin bus.atx_rdy = 1'b1; bus.m_awready_i = active && since >= 5; end
                3: begin bus.m_awready_i = 1'b1; bus.atx_rdy = active && since >= 5; end
                default: begin
                    bus.m_awready_i = ($urandom_range(0, 3) != 0);
                    bus.atx_rdy     = ($urandom_range(0, 3) != 0);
                end
            endcase
            req_fire = xfer_vld && xfer_rdy;
            if (req_fire) begin
                req_cyc = cyc; last_evt = cyc;
            end
            if (cur_aw && bus.m_awready_i) begin
                obs_addr.push_back(bus.m_awaddr_o);
                obs_len.push_back(int'(bus.m_awlen_o));
                if (active) aw_done = 1;
            end
            if (cur_atx && bus.atx_rdy) begin
                obs_atx.push_back(int'(bus.atx_awlen));
                if (active) atx_done = 1;
            end
            if (active && aw_done && atx_done) begin
                active = 0; last_evt = cyc;
            end
            @(negedge clk);
            cyc++;
            if (req_fire) xfer_vld = 1'b0;
        end
        xfer_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; xfer_vld = 1'b0; bus.m_awready_i = 1'b0; bus.atx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.m_awvalid_o !== 1'b0 || bus.atx_vld !== 1'b0 || xfer_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valids awvalid=%b atx_vld=%b done=%b want 0 0 0", bus.m_awvalid_o, bus.atx_vld, xfer_done);
        end
        n_cmp++;
        if (bus.m_awaddr_o !== 32'h0 || bus.m_awlen_o !== 8'h0 || bus.atx_awlen !== 8'h0) begin
            n_err++;
            $display("FAIL reset_regs awaddr=%h awlen=%h atx_awlen=%h want 0 0 0", bus.m_awaddr_o, bus.m_awlen_o, bus.atx_awlen);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (xfer_rdy !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release xfer_rdy=%b busy=%b want 1 0", xfer_rdy, busy);
        end
    endtask

    // Directed transfers: single burst, multi-burst, boundary split, empty transfer
    task automatic test_vectors();
        logic [31:0] va[5] = '{32'h0, 32'h0, 32'hFE0, 32'h0, 32'h1234_5F9B};
        int          vb[5] = '{4, 300, 4, 0, 77};
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 5; v++) begin
                drive_xfer(va[v], vb[v], 1 - m);
                n_cmp++;
                if (timeout !== 1'b0) begin n_err++; $display("FAIL vec%0d timeout=%b want 0", v, timeout); end
                n_cmp++;
                if (obs_addr.size() !== exp_addr.size() || obs_atx.size() !== exp_addr.size()) begin
                    n_err++;
                    $display("FAIL vec%0d burst_count aw=%0d atx=%0d want %0d", v, obs_addr.size(), obs_atx.size(), exp_addr.size());
                end
                for (int i = 0; i < exp_addr.size() && i < obs_addr.size() && i < obs_atx.size(); i++) begin
                    n_cmp++;
                    if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_atx[i] !== exp_len[i]) begin
                        n_err++;
                        $display("FAIL vec%0d burst%0d addr=%h len=%0d atx=%0d want %h %0d", v, i, obs_addr[i], obs_len[i], obs_atx[i], exp_addr[i], exp_len[i]);
                    end
                end
                n_cmp++;
                if (n_done !== 1 || done_lat !== 1) begin
                    n_err++;
                    $display("FAIL vec%0d done pulses=%0d lat=%0d want 1 1", v, n_done, done_lat);
                end
                n_cmp++;
                if (lat_bad + hold_bad + busy_bad + attr_bad !== 0) begin
                    n_err++;
                    $display("FAIL vec%0d protocol lat=%0d hold=%0d busy=%0d attr=%0d want 0", v, lat_bad, hold_bad, busy_bad, attr_bad);
                end
            end
        end
    endtask

    // One side stalls for 5 cycles per burst while the other accepts at once
    task automatic test_stall();
        for (int m = 2; m < 4; m++) begin
            for (int k = 0; k < 2; k++) begin
                drive_xfer((k == 0) ? 32'h0000_0F00 : ($urandom & 32'h7FFF_FFFF), (k == 0) ? 20 : $urandom_range(1, 400), m);
                n_cmp++;
                if (timeout !== 1'b0) begin n_err++; $display("FAIL stall%0d timeout=%b want 0", m, timeout); end
                n_cmp++;
                if (obs_addr.size() !== exp_addr.size() || obs_atx.size() !== exp_addr.size()) begin
                    n_err++;
                    $display("FAIL stall%0d burst_count aw=%0d atx=%0d want %0d", m, obs_addr.size(), obs_atx.size(), exp_addr.size());
                end
                for (int i = 0; i < exp_addr.size() && i < obs_addr.size() && i < obs_atx.size(); i++) begin
                    n_cmp++;
                    if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_atx[i] !== exp_len[i]) begin
                        n_err++;
                        $display("FAIL stall%0d burst%0d addr=%h len=%0d atx=%0d want %h %0d", m, i, obs_addr[i], obs_len[i], obs_atx[i], exp_addr[i], exp_len[i]);
                    end
                end
                n_cmp++;
                if (n_done !== 1 || done_lat !== 1 || stall_bad !== 0) begin
                    n_err++;
                    $display("FAIL stall%0d done=%0d lat=%0d stall_viol=%0d want 1 1 0", m, n_done, done_lat, stall_bad);
                end
                n_cmp++;
                if (lat_bad + hold_bad + busy_bad + attr_bad !== 0) begin
                    n_err++;
                    $display("FAIL stall%0d protocol lat=%0d hold=%0d busy=%0d attr=%0d want 0", m, lat_bad, hold_bad, busy_bad, attr_bad);
                end
            end
        end
    endtask

    // Random transfers issued back to back, new request right after each done
    task automatic test_back_to_back();
        logic [31:0] a;
        int          nb;
        for (int t = 0; t < 30; t++) begin
            a = $urandom & 32'h7FFF_FFFF;
            if ($urandom_range(0, 1) == 1) a = {a[31:12], 12'hF00 | 12'($urandom_range(0, 255))};
            nb = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 700);
            drive_xfer(a, nb, $urandom_range(0, 1));
            n_cmp++;
            if (timeout !== 1'b0) begin n_err++; $display("FAIL b2b%0d timeout=%b want 0", t, timeout); end
            n_cmp++;
            if (obs_addr.size() !== exp_addr.size() || obs_atx.size() !== exp_addr.size()) begin
                n_err++;
                $display("FAIL b2b%0d burst_count aw=%0d atx=%0d want %0d", t, obs_addr.size(), obs_atx.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size() && i < obs_atx.size(); i++) begin
                n_cmp++;
                if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_atx[i] !== exp_len[i]) begin
                    n_err++;
                    $display("FAIL b2b%0d burst%0d addr=%h len=%0d atx=%0d want %h %0d", t, i, obs_addr[i], obs_len[i], obs_atx[i], exp_addr[i], exp_len[i]);
                end
            end
            n_cmp++;
            if (n_done !== 1 || done_lat !== 1) begin
                n_err++;
                $display("FAIL b2b%0d done pulses=%0d lat=%0d want 1 1", t, n_done, done_lat);
            end
            n_cmp++;
            if (lat_bad + hold_bad + busy_bad + attr_bad !== 0) begin
                n_err++;
                $display("FAIL b2b%0d protocol lat=%0d hold=%0d busy=%0d attr=%0d want 0", t, lat_bad, hold_bad, busy_bad, attr_bad);
            end
        end
    endtask

    // Reset while a burst is pending on AW: everything drops, no done follows
    task automatic test_reset_mid();
        int  waited;
        bit  seen_done;
        @(negedge clk);
        bus.m_awready_i = 1'b0; bus.atx_rdy = 1'b0;
        xfer_addr = 32'h0000_0100; xfer_beats = 16'd10; xfer_vld = 1'b1;
        @(negedge clk);
        xfer_vld = 1'b0;
        waited = 0;
        while (bus.m_awvalid_o !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (bus.m_awvalid_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_setup awvalid=%b want 1", bus.m_awvalid_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.m_awvalid_o !== 1'b0 || bus.atx_vld !== 1'b0 || busy !== 1'b0 || xfer_rdy !== 1'b1 || xfer_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid awvalid=%b atx_vld=%b busy=%b rdy=%b done=%b want 0 0 0 1 0",
                     bus.m_awvalid_o, bus.atx_vld, busy, xfer_rdy, xfer_done);
        end
        rst_n = 1'b1;
        bus.m_awready_i = 1'b1; bus.atx_rdy = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (xfer_done || bus.m_awvalid_o || bus.atx_vld || !xfer_rdy) seen_done = 1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_after activity=%b want 0", seen_done);
        end
    endtask

    initial begin
        xfer_vld = 1'b0; xfer_addr = '0; xfer_beats = '0;
        bus.m_awready_i = 1'b0; bus.atx_rdy = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_vectors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
